seq_divider: RTL and testbench

Sequential restoring shift-subtract divider, the inverse companion of the team's sequential shift-add multiplier. It divides a 2*d_width-bit unsigned dividend by a d_width-bit unsigned divisor over d_width shift/subtract iterations, producing a d_width-bit quotient and a d_width-bit remainder. It sits in the bfloat16 datapath and serves mantissa division (d_width=8: 8-bit significand with hidden bit). It uses a start/ready/done handshake.

---
 rtl/seq_divider.sv | 135 +++++++++++++
 tb/tb_seq_divider.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Sequential restoring shift-subtract divider: a 2*d_width-bit dividend divided by a
// d_width-bit divisor, one shift/subtract pair per quotient bit, start/ready/done handshake.
module seq_divider #(
    parameter int d_width = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [2*d_width-1:0]   dividend,
    input  logic [d_width-1:0]     divisor,
    output logic [d_width-1:0]     quotient,
    output logic [d_width-1:0]     remainder,
    output logic                   ready,
    output logic                   done,
    output logic                   div_by_zero,
    output logic                   overflow
);

    localparam int P_W = $clog2(d_width + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_SHIFT,
        S_SUB,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [d_width-1:0] r_q, r_d;
    logic [d_width-1:0] q_q, q_d;
    logic [d_width-1:0] b_q, b_d;
    logic               c_q, c_d;
    logic [P_W-1:0]     p_q, p_d;
    logic               dbz_q, dbz_d;
    logic               ovf_q, ovf_d;
    logic [d_width:0]   diff;

    // {C,R} < 2*B after every shift, so the sign bit of this difference is the borrow.
    assign diff = {c_q, r_q} - {1'b0, b_q};

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path infers a latch.
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        b_d     = b_q;
        c_d     = c_q;
        p_d     = p_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    r_d     = dividend[2*d_width-1:d_width];
                    q_d     = dividend[d_width-1:0];
                    b_d     = divisor;
                    c_d     = 1'b0;
                    p_d     = P_W'(d_width);
                    dbz_d   = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                // Error results are zeroed here so the outputs stay purely registered.
                if (b_q == '0) begin
                    dbz_d   = 1'b1;
                    r_d     = '0;
                    q_d     = '0;
                    state_d = S_DONE;
                end else if (r_q >= b_q) begin
                    ovf_d   = 1'b1;
                    r_d     = '0;
                    q_d     = '0;
                    state_d = S_DONE;
                end else begin
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                {c_d, r_d, q_d} = {r_q, q_q, 1'b0};
                p_d             = p_q - P_W'(1);
                state_d         = S_SUB;
            end
            S_SUB: begin
                if (!diff[d_width]) begin
                    r_d    = diff[d_width-1:0];
                    q_d[0] = 1'b1;
                end
                c_d     = 1'b0;
                state_d = (p_q == '0) ? S_DONE : S_SHIFT;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, and every register,
    // including the datapath, is cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            q_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            p_q     <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            b_q     <= b_d;
            c_q     <= c_d;
            p_q     <= p_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign quotient    = q_q;
    assign remainder   = r_q;
    assign ready       = (state_q == S_IDLE);
    assign done        = (state_q == S_DONE);
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (d_width=8): directed cases, handshake corner
// cases and a randomized sweep compared against an arithmetic reference model.
module tb_seq_divider;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        ready;
    logic        done;
    logic        div_by_zero;
    logic        overflow;

    int checks;
    int failures;
    int cyc;

    typedef struct {
        int q;
        int r;
        bit dbz;
        bit ovf;
        int lat;
    } exp_t;

    seq_divider #(.d_width(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .quotient   (quotient),
        .remainder  (remainder),
        .ready      (ready),
        .done       (done),
        .div_by_zero(div_by_zero),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: plain integer division plus the two error rules.
    function automatic exp_t model(input logic [15:0] dvd, input logic [7:0] dvs);
        exp_t m;
        int   full;
        m = '{q: 0, r: 0, dbz: 1'b0, ovf: 1'b0, lat: 2};
        if (dvs == 8'd0) begin
            m.dbz = 1'b1;
        end else begin
            full = int'(dvd) / int'(dvs);
            if (full > 255) begin
                m.ovf = 1'b1;
            end else begin
                m.q   = full;
                m.r   = int'(dvd) % int'(dvs);
                m.lat = 18;
            end
        end
        return m;
    endfunction

    // Called at a falling edge with the DUT idle; returns at the first falling edge after acceptance (cyc=1).
    task automatic accept(input logic [15:0] dvd, input logic [7:0] dvs, input logic keep);
        check("ready_before_start", ready, 1);
        start    = 1'b1;
        dividend = dvd;
        divisor  = dvs;
        @(posedge clk);
        @(negedge clk);
        if (!keep) start = 1'b0;
        cyc = 1;
    endtask

    task automatic wait_done();
        while (done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("done_seen", done, 1);
    endtask

    task automatic check_result(input exp_t m);
        check("latency", cyc, m.lat);
        check("quotient", quotient, m.q);
        check("remainder", remainder, m.r);
        check("div_by_zero", div_by_zero, m.dbz);
        check("overflow", overflow, m.ovf);
        check("ready_in_done", ready, 0);
    endtask

    task automatic check_after(input exp_t m);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("ready_returns", ready, 1);
        check("quotient_held", quotient, m.q);
        check("remainder_held", remainder, m.r);
    endtask

    task automatic run_op(input logic [15:0] dvd, input logic [7:0] dvs);
        exp_t m;
        m = model(dvd, dvs);
        accept(dvd, dvs, 1'b0);
        wait_done();
        check_result(m);
        if (!m.dbz && !m.ovf) begin
            check("identity", int'(quotient) * int'(dvs) + int'(remainder), int'(dvd));
            check("rem_lt_div", (int'(remainder) < int'(dvs)) ? 1 : 0, 1);
        end
        check_after(m);
    endtask

    initial begin
        exp_t        m1;
        exp_t        m2;
        logic [7:0]  dvs;
        logic [7:0]  hi;
        logic [7:0]  lo;

        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;

        repeat (2) @(negedge clk);
        check("rst_ready", ready, 1);
        check("rst_done", done, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_dbz", div_by_zero, 0);
        check("rst_ovf", overflow, 0);
        reset = 1'b1;
        @(negedge clk);

        // Directed values, including error cases after a nonzero result.
        run_op(16'h1234, 8'h56);
        run_op(16'h4000, 8'h80);
        run_op(16'hFE01, 8'hFF);
        run_op(16'h0010, 8'h00);
        run_op(16'h1234, 8'h56);
        run_op(16'h1000, 8'h10);
        run_op(16'h0000, 8'h00);
        run_op(16'h0000, 8'h01);
        run_op(16'h00FF, 8'h01);
        run_op(16'hFFFF, 8'hFF);

        // A start pulse while busy must not disturb the operation in flight.
        m1 = model(16'h1234, 8'h56);
        accept(16'h1234, 8'h56, 1'b0);
        while (cyc < 5) begin
            @(negedge clk);
            cyc++;
        end
        start    = 1'b1;
        dividend = 16'hFFFF;
        divisor  = 8'h01;
        @(negedge clk);
        cyc++;
        start = 1'b0;
        wait_done();
        check_result(m1);
        check_after(m1);

        // start held high: the next operation is accepted as soon as ready returns.
        m1 = model(16'h4000, 8'h80);
        m2 = model(16'hFE01, 8'hFF);
        accept(16'h4000, 8'h80, 1'b1);
        wait_done();
        check_result(m1);
        dividend = 16'hFE01;
        divisor  = 8'hFF;
        @(negedge clk);
        check("hold_ready", ready, 1);
        @(posedge clk);
        @(negedge clk);
        check("hold_accepted", ready, 0);
        start = 1'b0;
        cyc   = 1;
        wait_done();
        check_result(m2);
        check_after(m2);

        // Reset in the middle of an operation.
        accept(16'h1234, 8'h56, 1'b0);
        while (cyc < 8) begin
            @(negedge clk);
            cyc++;
        end
        reset = 1'b0;
        #1;
        check("midrst_ready", ready, 1);
        check("midrst_done", done, 0);
        check("midrst_quotient", quotient, 0);
        check("midrst_remainder", remainder, 0);
        check("midrst_dbz", div_by_zero, 0);
        check("midrst_ovf", overflow, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst_no_done", done, 0);
        end
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_no_done", done, 0);
        run_op(16'h00FF, 8'h0F);

        // Random sweep of valid operations (high half below the divisor).
        for (int i = 0; i < 600; i++) begin
            dvs = 8'($urandom_range(1, 255));
            hi  = 8'($urandom_range(0, int'(dvs) - 1));
            lo  = 8'($urandom_range(0, 255));
            run_op({hi, lo}, dvs);
        end

        // Unconstrained operands, so error cases appear too.
        for (int i = 0; i < 150; i++) begin
            dvs = (i % 10 == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            run_op(16'($urandom), dvs);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
